// File: rtl/cory_vr2sbd_if.sv
// rtl/cory_vr2sbd_if.sv - valid/ready request channel into cory_vr2sbd
interface cory_vr2sbd_if #(
  parameter int W = 8
) ();
  logic         i_v;
  logic         o_r;
  logic [W-1:0] i_data;

  modport master (output i_v, output i_data, input  o_r);
  modport slave  (input  i_v, input  i_data, output o_r);
endinterface

// File: rtl/cory_vr2sbd.sv
// rtl/cory_vr2sbd.sv - valid/ready request queue driving a start/done engine
// Each accepted word becomes one o_start strobe; next start waits for i_done or timeout.
module cory_vr2sbd #(
  parameter int W       = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 256,
  parameter int CW      = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  cory_vr2sbd_if.slave               s_req,
  output logic                       o_start,
  output logic [W-1:0]               o_data,
  input  logic                       i_done,
  output logic                       o_busy,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic                       o_timeout,
  output logic                       o_err,
  input  logic                       i_clr_err,
  output logic [CW-1:0]              o_cnt
);
  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = AW + 1;
  localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [LW-1:0] r_level;
  logic [1:0]    r_state;
  logic [TW-1:0] r_tcnt;
  logic          r_start;
  logic [W-1:0]  r_data;
  logic          r_timeout;
  logic          r_err;
  logic [CW-1:0] r_cnt;

  logic          w_push;
  logic          w_pop;
  logic [AW:0]   w_rd_inc;
  logic [W-1:0]  w_head;
  logic [1:0]    w_next;
  logic          w_done_run;
  logic          w_to;
  logic          w_spur;

  assign s_req.o_r = (r_level != LW'(DEPTH));
  assign w_push    = s_req.i_v && s_req.o_r;
  assign w_pop     = (r_state == S_START);
  assign w_rd_inc  = r_rd_ptr + 1'b1;

  // In START the current head is popped this cycle, so the next run uses the entry behind it.
  assign w_head = (r_state == S_START) ? r_mem[w_rd_inc[AW-1:0]] : r_mem[r_rd_ptr[AW-1:0]];

  always_comb begin
    w_next     = r_state;
    w_done_run = 1'b0;
    w_to       = 1'b0;
    w_spur     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_done) w_spur = 1'b1;
        if (r_level != '0) w_next = S_START;
      end
      S_START: begin
        if (i_done) begin
          w_done_run = 1'b1;
          // A word pushed this same cycle is not yet visible; it starts via IDLE instead.
          w_next = (r_level >= LW'(2)) ? S_START : S_IDLE;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_done) begin
          w_done_run = 1'b1;
          w_next = (r_level != '0) ? S_START : S_IDLE;
        end else if (TIMEOUT != 0 && r_tcnt == TW'(TLIM)) begin
          w_to   = 1'b1;
          w_next = (r_level != '0) ? S_START : S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= s_req.i_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_state   <= S_IDLE;
      r_tcnt    <= '0;
      r_start   <= 1'b0;
      r_data    <= '0;
      r_timeout <= 1'b0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= w_rd_inc;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      r_state   <= w_next;
      r_start   <= (w_next == S_START);
      if (w_next == S_START) r_data <= w_head;
      // Counting through START makes the abandon land TIMEOUT cycles after the strobe.
      r_tcnt    <= (w_next == S_START) ? '0 : r_tcnt + 1'b1;
      r_timeout <= w_to;
      if (w_done_run) r_cnt <= r_cnt + 1'b1;
      if (w_to || w_spur) r_err <= 1'b1;
      else if (i_clr_err) r_err <= 1'b0;
    end
  end

  assign o_start   = r_start;
  assign o_data    = r_data;
  assign o_level   = r_level;
  assign o_timeout = r_timeout;
  assign o_err     = r_err;
  assign o_cnt     = r_cnt;
  assign o_busy    = (r_state != S_IDLE) || (r_level != '0);
endmodule

// File: tb/tb_cory_vr2sbd.sv
// tb/tb_cory_vr2sbd.sv - directed self-checking bench for cory_vr2sbd
module tb_cory_vr2sbd;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  cory_vr2sbd_if #(.W(8)) req_a ();
  cory_vr2sbd_if #(.W(8)) req_b ();

  logic       start_a, busy_a, tmo_a, err_a, clr_a, done_drv_a, tie_a;
  logic [7:0] data_a;
  logic [2:0] level_a;
  logic [15:0] cnt_a;
  logic       done_a;
  assign done_a = tie_a ? start_a : done_drv_a;

  logic       start_b, busy_b, tmo_b, err_b, done_b;
  logic [7:0] data_b;
  logic [2:0] level_b;
  logic [15:0] cnt_b;

  cory_vr2sbd #(.W(8), .DEPTH(4), .TIMEOUT(8), .CW(16)) u_a (
    .clk(clk), .reset(reset), .s_req(req_a.slave), .o_start(start_a), .o_data(data_a),
    .i_done(done_a), .o_busy(busy_a), .o_level(level_a), .o_timeout(tmo_a),
    .o_err(err_a), .i_clr_err(clr_a), .o_cnt(cnt_a));

  cory_vr2sbd #(.W(8), .DEPTH(4), .TIMEOUT(0), .CW(16)) u_b (
    .clk(clk), .reset(reset), .s_req(req_b.slave), .o_start(start_b), .o_data(data_b),
    .i_done(done_b), .o_busy(busy_b), .o_level(level_b), .o_timeout(tmo_b),
    .o_err(err_b), .i_clr_err(1'b0), .o_cnt(cnt_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (req_a.o_r !== 1'b1) begin n_fail++; $display("FAIL rst_r got %b want 1", req_a.o_r); end
    n_checks++; if (start_a !== 1'b0) begin n_fail++; $display("FAIL rst_start got %b want 0", start_a); end
    n_checks++; if (data_a !== 8'h00) begin n_fail++; $display("FAIL rst_data got %h want 00", data_a); end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy_a); end
    n_checks++; if (level_a !== 3'd0) begin n_fail++; $display("FAIL rst_level got %0d want 0", level_a); end
    n_checks++; if (tmo_a !== 1'b0) begin n_fail++; $display("FAIL rst_timeout got %b want 0", tmo_a); end
    n_checks++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b want 0", err_a); end
    n_checks++; if (cnt_a !== 16'd0) begin n_fail++; $display("FAIL rst_cnt got %0d want 0", cnt_a); end
  endtask

  task automatic test_single();
    do_reset();
    req_a.i_v = 1'b1; req_a.i_data = 8'h5A;
    tick();
    req_a.i_v = 1'b0;
    n_checks++; if (start_a !== 1'b0 || level_a !== 3'd1) begin n_fail++; $display("FAIL single_acc start=%b level=%0d want 0/1", start_a, level_a); end
    tick();
    n_checks++; if (start_a !== 1'b1 || data_a !== 8'h5A) begin n_fail++; $display("FAIL single_start start=%b data=%h want 1/5a", start_a, data_a); end
    tick();
    n_checks++; if (start_a !== 1'b0 || data_a !== 8'h5A || busy_a !== 1'b1) begin n_fail++; $display("FAIL single_wait start=%b data=%h busy=%b want 0/5a/1", start_a, data_a, busy_a); end
    tick();
    tick();
    done_drv_a = 1'b1;
    n_checks++; if (data_a !== 8'h5A || cnt_a !== 16'd0) begin n_fail++; $display("FAIL single_hold data=%h cnt=%0d want 5a/0", data_a, cnt_a); end
    tick();
    done_drv_a = 1'b0;
    n_checks++; if (cnt_a !== 16'd1 || busy_a !== 1'b0 || start_a !== 1'b0) begin n_fail++; $display("FAIL single_done cnt=%0d busy=%b start=%b want 1/0/0", cnt_a, busy_a, start_a); end
  endtask

  task automatic test_fill();
    do_reset();
    req_b.i_v = 1'b1;
    for (int k = 0; k < 6; k++) begin
      req_b.i_data = 8'h10 + 8'(k);
      tick();
    end
    req_b.i_v = 1'b0;
    n_checks++; if (level_b !== 3'd4 || req_b.o_r !== 1'b0) begin n_fail++; $display("FAIL fill_full level=%0d r=%b want 4/0", level_b, req_b.o_r); end
    n_checks++; if (data_b !== 8'h10 || busy_b !== 1'b1) begin n_fail++; $display("FAIL fill_inflight data=%h busy=%b want 10/1", data_b, busy_b); end
    tick();
    n_checks++; if (level_b !== 3'd4 || start_b !== 1'b0) begin n_fail++; $display("FAIL fill_hold level=%0d start=%b want 4/0", level_b, start_b); end
    for (int k = 1; k <= 4; k++) begin
      done_b = 1'b1;
      tick();
      done_b = 1'b0;
      n_checks++; if (start_b !== 1'b1 || data_b !== 8'h10 + 8'(k)) begin n_fail++; $display("FAIL fill_order%0d start=%b data=%h want 1/%h", k, start_b, data_b, 8'h10 + 8'(k)); end
      tick();
    end
    done_b = 1'b1;
    tick();
    done_b = 1'b0;
    n_checks++; if (cnt_b !== 16'd5 || level_b !== 3'd0 || busy_b !== 1'b0 || start_b !== 1'b0) begin n_fail++; $display("FAIL fill_drain cnt=%0d level=%0d busy=%b start=%b want 5/0/0/0", cnt_b, level_b, busy_b, start_b); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    tie_a = 1'b1;
    req_a.i_v = 1'b1;
    req_a.i_data = 8'h01; tick();
    req_a.i_data = 8'h02; tick();
    n_checks++; if (start_a !== 1'b1 || data_a !== 8'h01) begin n_fail++; $display("FAIL b2b_1 start=%b data=%h want 1/01", start_a, data_a); end
    req_a.i_data = 8'h03; tick();
    req_a.i_v = 1'b0;
    n_checks++; if (start_a !== 1'b1 || data_a !== 8'h02 || cnt_a !== 16'd1) begin n_fail++; $display("FAIL b2b_2 start=%b data=%h cnt=%0d want 1/02/1", start_a, data_a, cnt_a); end
    tick();
    n_checks++; if (start_a !== 1'b1 || data_a !== 8'h03) begin n_fail++; $display("FAIL b2b_3 start=%b data=%h want 1/03", start_a, data_a); end
    tick();
    n_checks++; if (start_a !== 1'b0 || cnt_a !== 16'd3 || busy_a !== 1'b0) begin n_fail++; $display("FAIL b2b_end start=%b cnt=%0d busy=%b want 0/3/0", start_a, cnt_a, busy_a); end
    tie_a = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    req_a.i_v = 1'b1;
    req_a.i_data = 8'hA1; tick();
    req_a.i_data = 8'hA2; tick();
    req_a.i_v = 1'b0;
    n_checks++; if (start_a !== 1'b1 || data_a !== 8'hA1) begin n_fail++; $display("FAIL to_start start=%b data=%h want 1/a1", start_a, data_a); end
    for (int k = 1; k < 8; k++) begin
      tick();
      n_checks++; if (tmo_a !== 1'b0 || start_a !== 1'b0) begin n_fail++; $display("FAIL to_early%0d timeout=%b start=%b want 0/0", k, tmo_a, start_a); end
    end
    tick();
    n_checks++; if (tmo_a !== 1'b1 || err_a !== 1'b1 || cnt_a !== 16'd0) begin n_fail++; $display("FAIL to_pulse timeout=%b err=%b cnt=%0d want 1/1/0", tmo_a, err_a, cnt_a); end
    n_checks++; if (start_a !== 1'b1 || data_a !== 8'hA2) begin n_fail++; $display("FAIL to_next start=%b data=%h want 1/a2", start_a, data_a); end
    tick();
    n_checks++; if (tmo_a !== 1'b0 || err_a !== 1'b1) begin n_fail++; $display("FAIL to_once timeout=%b err=%b want 0/1", tmo_a, err_a); end
    clr_a = 1'b1; tick(); clr_a = 1'b0;
    n_checks++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL to_clr err=%b want 0", err_a); end
    done_drv_a = 1'b1; tick(); done_drv_a = 1'b0;
    n_checks++; if (cnt_a !== 16'd1 || busy_a !== 1'b0) begin n_fail++; $display("FAIL to_done cnt=%0d busy=%b want 1/0", cnt_a, busy_a); end
  endtask

  task automatic test_spurious();
    do_reset();
    done_drv_a = 1'b1; clr_a = 1'b1;
    tick();
    done_drv_a = 1'b0; clr_a = 1'b0;
    n_checks++; if (err_a !== 1'b1 || cnt_a !== 16'd0) begin n_fail++; $display("FAIL spur_err err=%b cnt=%0d want 1/0", err_a, cnt_a); end
    tick();
    n_checks++; if (start_a !== 1'b0 || busy_a !== 1'b0) begin n_fail++; $display("FAIL spur_idle start=%b busy=%b want 0/0", start_a, busy_a); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_a.i_v = 1'b1;
    req_a.i_data = 8'hB1; tick();
    req_a.i_data = 8'hB2; tick();
    req_a.i_data = 8'hB3; tick();
    req_a.i_v = 1'b0;
    n_checks++; if (level_a !== 3'd2 || busy_a !== 1'b1 || start_a !== 1'b0) begin n_fail++; $display("FAIL mid_pre level=%0d busy=%b start=%b want 2/1/0", level_a, busy_a, start_a); end
    reset = 1'b1; tick(); reset = 1'b0;
    n_checks++; if (level_a !== 3'd0 || busy_a !== 1'b0 || req_a.o_r !== 1'b1 || start_a !== 1'b0 || tmo_a !== 1'b0) begin n_fail++; $display("FAIL mid_rst level=%0d busy=%b r=%b start=%b to=%b want 0/0/1/0/0", level_a, busy_a, req_a.o_r, start_a, tmo_a); end
    tick();
    done_drv_a = 1'b1; tick(); done_drv_a = 1'b0;
    n_checks++; if (err_a !== 1'b1 || cnt_a !== 16'd0 || busy_a !== 1'b0) begin n_fail++; $display("FAIL mid_spur err=%b cnt=%0d busy=%b want 1/0/0", err_a, cnt_a, busy_a); end
  endtask

  initial begin
    req_a.i_v = 1'b0; req_a.i_data = 8'h00;
    req_b.i_v = 1'b0; req_b.i_data = 8'h00;
    clr_a = 1'b0; done_drv_a = 1'b0; tie_a = 1'b0; done_b = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_timeout();
    test_spurious();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cory_vr2sbd.md
Name: cory_vr2sbd

Overview:
- Inverse of the team's start/done-to-valid/ready converter: accepts valid/ready transactions carrying a data word and turns each one into a single-cycle start strobe with data on a start/busy/done interface.
- Waits for the downstream engine's done before issuing the next start.
- Buffers incoming requests in a small FIFO, supervises each engine run with a timeout, and reports status (level, busy, error, completion count).
- Sits in front of strobe-driven engines that are fed from valid/ready pipelines.

Parameters:
W, 8, data word width carried per transaction
DEPTH, 4, request FIFO entries; power of 2, >= 2
TIMEOUT, 256, max cycles spent in WAIT before abandoning; 0 disables timeout
CW, 16, width of completed-transaction counter

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous active-high reset
i_v  input  1  request valid
o_r  output  1  request ready
i_data  input  W  request data
o_start  output  1  one-cycle start strobe to engine
o_data  output  W  data for engine; held stable from start until leaving WAIT
i_done  input  1  engine completion strobe
o_busy  output  1  transaction pending or in flight
o_level  output  log2(DEPTH)+1  FIFO occupancy
o_timeout  output  1  one-cycle pulse when a run is abandoned
o_err  output  1  sticky error: timeout or spurious done
i_clr_err  input  1  clears o_err
o_cnt  output  CW  runs completed by i_done; wraps modulo 2^CW

Behaviour:
- Reset (sync, active-high, sampled on clk rising edge) flushes the FIFO, forces state IDLE, clears the timeout counter and o_cnt, clears o_err.
- Reset values: o_r=1, o_start=0, o_data=0, o_busy=0, o_level=0, o_timeout=0, o_err=0, o_cnt=0.
- Reset mid-run drops the in-flight and queued transactions silently. No o_timeout pulse and no o_cnt increment.
- Accept:
  - push when i_v && o_r at a rising edge;
  - o_r = (o_level != DEPTH), combinational from registered level only (no dependency on i_v);
  - push and pop in the same cycle are both honoured; level unchanged;
  - pointers carry an extra wrap bit.
- FSM states IDLE, START, WAIT:
  - IDLE: FIFO non-empty -> START.
  - START (exactly one cycle): o_start=1; o_data loads the FIFO head; head is popped this cycle.
    - i_done also high this cycle: the run completes immediately, o_cnt+1, next state = START if FIFO non-empty after the pop, else IDLE.
    - Otherwise -> WAIT.
  - WAIT: o_start=0, o_data held.
    - i_done=1: o_cnt+1, then -> START if FIFO non-empty, else IDLE.
    - Else if TIMEOUT!=0 and the timeout counter == TIMEOUT-1: -> IDLE (or START if non-empty), o_timeout=1 for one cycle, o_err set.
    - Else the counter increments.
    - Counter clears on every entry to START.
- Latency: a request accepted at edge N into an empty FIFO with FSM in IDLE gives o_start=1 in the cycle following edge N+1, i.e. 2 cycles.
- Peak throughput: one start every 2 cycles (START, WAIT with immediate done). Back-to-back START->START is allowed only when done arrives in the START cycle.
- i_done while IDLE is spurious: ignored functionally, sets o_err, no o_cnt change.
- o_err set and i_clr_err in the same cycle: set wins.
- o_busy = (state != IDLE) || (o_level != 0).
- o_timeout and i_done in the same cycle cannot conflict: done has priority and there is no timeout pulse.
- All outputs registered except o_r and o_busy, which decode registered state.

Test Plan:
- Single request: reset, i_v=1 i_data=0x5A for one cycle, i_done 3 cycles after o_start -> o_start high exactly 1 cycle, 2 cycles after accept, o_data=0x5A held until done; o_cnt=1, o_busy drops the cycle after done.
- Fill/backpressure: engine never signals done and TIMEOUT=0; push 6 words -> 1 word in flight, o_level reaches 4, o_r=0. Extra word is not accepted. After done pulses, words emerge in order.
- Done in START cycle: tie i_done=o_start with 3 queued words 0x01,0x02,0x03 -> three consecutive o_start cycles; o_cnt=3 on the following cycle.
- Timeout: TIMEOUT=8, no done -> o_timeout pulses once, 8 cycles after o_start; o_err=1, o_cnt unchanged; next queued word starts. i_clr_err clears o_err.
- Spurious done: i_done in IDLE -> o_err=1, o_cnt=0, FSM stays IDLE.
- Reset mid-operation: assert reset while in WAIT with 2 queued -> next cycle o_level=0, o_busy=0, o_r=1, o_start=0. A later done is treated as spurious.
